// File: rtl/alu_operand_loader.sv
// alu_operand_loader
//   Builds the two 32-bit ALU operands A and B one byte at a time from the
//   slide switches. Each byte is committed by a debounced press of btn_load,
//   least-significant byte first: four bytes for A, then four for B, then READY.
//   btn_clr, or btn_load while READY, restarts entry with A = B = 0.
//
//   Build option: define LOADER_DEBOUNCE_EN to include the debounce filter.
//   Without it the filter is bypassed, which is meant for fast simulation only.
//   In that build DB_CYCLES and DB_W have no effect.
//
// Ports
//   clk, rst_n      rising-edge clock; asynchronous active-low reset
//   sw[7:0]         data byte from the slide switches
//   btn_load        raw push button that commits sw as the next byte
//   btn_clr         raw push button that restarts entry
//   A, B [31:0]     operands; partially loaded bytes are visible during entry
//   operands_valid  high while both operands are complete
//   phase[1:0]      00 LOAD_A, 01 LOAD_B, 10 READY
//   byte_idx[1:0]   index of the next byte to be written

// Conditions one raw button: 2-FF synchronizer, optional debounce filter,
// then a registered rising-edge detector that emits a one-cycle pulse.
module alu_operand_loader_btn #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);
  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic sync1_d, sync2_d, prev_d, pulse_d;
  logic stable;

`ifdef LOADER_DEBOUNCE_EN
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  // The counter only runs while the synchronized level disagrees with the
  // accepted level. Any return to agreement clears it, so short glitches are
  // thrown away.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync2_q;

  // The filter parameters have no hardware in this build.
  if (DB_CYCLES == 0 || DB_W == 0) begin : g_filter_params_unused
  end
`endif

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = stable;
    pulse_d = stable & ~prev_q;
  end

  // The stable level resets to 0, so a button held through reset release is
  // seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

module alu_operand_loader #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic        btn_load,
  input  logic        btn_clr,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        operands_valid,
  output logic [1:0]  phase,
  output logic [1:0]  byte_idx
);
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } phase_e;

  localparam int NUM_BTN = 2;  // [0] load, [1] clear

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic               load_p, clr_p;

  assign btn_raw = {btn_clr, btn_load};
  assign load_p  = btn_pulse[0];
  assign clr_p   = btn_pulse[1];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    alu_operand_loader_btn #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .pulse   (btn_pulse[i])
    );
  end

  phase_e      phase_q, phase_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        restart;

  always_comb begin
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    restart = 1'b0;

    // clr_p is checked first, so a simultaneous load_p is discarded.
    if (clr_p) begin
      restart = 1'b1;
    end else begin
      case (phase_q)
        LOAD_A: if (load_p) begin
          a_d[{idx_q, 3'b000} +: 8] = sw;
          if (idx_q == 2'd3) begin
            phase_d = LOAD_B;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        LOAD_B: if (load_p) begin
          b_d[{idx_q, 3'b000} +: 8] = sw;
          if (idx_q == 2'd3) begin
            phase_d = READY;
            idx_d   = 2'd0;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        READY:   if (load_p) restart = 1'b1;
        default: restart = 1'b1;  // 2'b11 is unreachable; recover to LOAD_A
      endcase
    end

    if (restart) begin
      phase_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      idx_d   = 2'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign operands_valid = valid_q;
  assign phase          = phase_q;
  assign byte_idx       = idx_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DB_CYCLES = 4.
// Inputs are driven on the falling edge. Outputs are sampled either on the
// falling edge or #1 after the rising edge.
module tb_alu_operand_loader;
  localparam int unsigned DB_CYCLES = 4;
  localparam int unsigned DB_W      = 3;
`ifdef LOADER_DEBOUNCE_EN
  localparam int COMMIT_EDGE = DB_CYCLES + 4;
`else
  localparam int COMMIT_EDGE = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  sw = 8'h00;
  logic        btn_load = 1'b0;
  logic        btn_clr = 1'b0;
  logic [31:0] A, B;
  logic        operands_valid;
  logic [1:0]  phase, byte_idx;

  int checks = 0;
  int failures = 0;

  alu_operand_loader #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clr        (btn_clr),
    .A              (A),
    .B              (B),
    .operands_valid (operands_valid),
    .phase          (phase),
    .byte_idx       (byte_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                         input logic ev, input logic [1:0] ep, input logic [1:0] ei);
    chk({tag, ".A"}, A, ea);
    chk({tag, ".B"}, B, eb);
    chk({tag, ".valid"}, {31'd0, operands_valid}, {31'd0, ev});
    chk({tag, ".phase"}, {30'd0, phase}, {30'd0, ep});
    chk({tag, ".idx"}, {30'd0, byte_idx}, {30'd0, ei});
  endtask

  // Holds the button(s) long enough for a press to be accepted, then releases
  // long enough for the release to be accepted too.
  task automatic press(input logic [7:0] val, input logic ld, input logic cl);
    @(negedge clk);
    sw = val; btn_load = ld; btn_clr = cl;
    repeat (12) @(negedge clk);
    btn_load = 1'b0; btn_clr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    // Asynchronous reset, checked before any rising clock edge.
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 32'h0, 32'h0, 1'b0, 2'b00, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Press latency and a single commit for a long hold.
    sw = 8'hA5; btn_load = 1'b1;
    for (int e = 1; e <= COMMIT_EDGE; e++) begin
      @(posedge clk); #1;
      if (e == COMMIT_EDGE - 1) chk("lat.before", A, 32'h0);
      if (e == COMMIT_EDGE) begin
        chk("lat.at", A, 32'h0000_00A5);
        chk("lat.idx", {30'd0, byte_idx}, 32'd1);
      end
    end
    repeat (100 - COMMIT_EDGE) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    chk_all("hold1", 32'h0000_00A5, 32'h0, 1'b0, 2'b00, 2'd1);

    // Clear from LOAD_A.
    press(8'hFF, 1'b0, 1'b1);
    chk_all("clrA", 32'h0, 32'h0, 1'b0, 2'b00, 2'd0);

    // Full load of eight bytes, LSB first.
    for (int i = 1; i <= 8; i++) begin
      press(8'(i * 8'h11), 1'b1, 1'b0);
      if (i == 2) chk_all("part2", 32'h0000_2211, 32'h0, 1'b0, 2'b00, 2'd2);
      if (i == 4) chk_all("doneA", 32'h4433_2211, 32'h0, 1'b0, 2'b01, 2'd0);
    end
    chk_all("full", 32'h4433_2211, 32'h8877_6655, 1'b1, 2'b10, 2'd0);

`ifdef LOADER_DEBOUNCE_EN
    // Bounce: 3 cycles high, 2 low, repeated. Never held long enough.
    sw = 8'h99;
    for (int r = 0; r < 5; r++) begin
      btn_load = 1'b1; repeat (3) @(negedge clk);
      btn_load = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk_all("bounce", 32'h4433_2211, 32'h8877_6655, 1'b1, 2'b10, 2'd0);
`endif

    // Load in READY restarts entry and does not store sw.
    press(8'hEE, 1'b1, 1'b0);
    chk_all("rdyload", 32'h0, 32'h0, 1'b0, 2'b00, 2'd0);

    // Reach LOAD_B byte 2, then clear and load on the same edge.
    for (int i = 1; i <= 6; i++) press(8'(i), 1'b1, 1'b0);
    chk_all("b2", 32'h0403_0201, 32'h0000_0605, 1'b0, 2'b01, 2'd2);
    press(8'h77, 1'b1, 1'b1);
    chk_all("clrld", 32'h0, 32'h0, 1'b0, 2'b00, 2'd0);

    // Asynchronous reset pulse between edges while in LOAD_B.
    for (int i = 1; i <= 5; i++) press(8'(8'hC0 + i), 1'b1, 1'b0);
    chk_all("midB", 32'hC4C3_C2C1, 32'h0000_00C5, 1'b0, 2'b01, 2'd1);
    #2 rst_n = 1'b0;
    #1 chk_all("arst", 32'h0, 32'h0, 1'b0, 2'b00, 2'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(8'h5A, 1'b1, 1'b0);
    chk_all("postrst", 32'h0000_005A, 32'h0, 1'b0, 2'b00, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: bench did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end input block for the ALU lab top level: the write side of the switch/LED data path that the ALU display side reads. It assembles the two 32-bit ALU operands A and B one byte at a time from eight slide switches, committing each byte on a debounced push-button press. Its A/B outputs replace the fixed test-pattern operand source feeding the ALU core. Phase and byte-index outputs drive progress LEDs.

## Interface
- DB_CYCLES, 500000, consecutive clock cycles a synchronized button level must persist before it is accepted (10 ms at 50 MHz); minimum 1
- DB_W, 20, counter width; must satisfy 2^DB_W > DB_CYCLES
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- sw  input  8  data byte from slide switches
- btn_load  input  1  raw push button, active-high, commits sw as next byte
- btn_clr  input  1  raw push button, active-high, restarts entry
- A  output  32  operand A
- B  output  32  operand B
- operands_valid  output  1  high while A and B are both complete
- phase  output  2  00 LOAD_A, 01 LOAD_B, 10 READY (11 unused)
- byte_idx  output  2  index of the next byte to be written

## Operation
- Each button passes through: 2-FF synchronizer -> debounce filter -> rising-edge detector producing a one-cycle pulse (load_p, clr_p).
- Debounce filter: counter resets whenever the synchronized level equals the stable level; otherwise it increments; when it reaches DB_CYCLES the stable level flips and the counter clears. Glitches shorter than DB_CYCLES cycles are discarded. Release is filtered identically; only press (rising edge of stable) produces a pulse.
- LOAD_A, load_p: A[8*byte_idx +: 8] <= sw; byte_idx++; on byte_idx==3 go to LOAD_B, byte_idx <= 0. Byte order LSB first.
- LOAD_B, load_p: same on B; after byte 3 go to READY, byte_idx <= 0, operands_valid <= 1.
- READY, load_p: go to LOAD_A, A <= 0, B <= 0, operands_valid <= 0, byte_idx <= 0; sw is not written on this press.
- clr_p in any state: same as the READY restart. clr_p wins over a simultaneous load_p; that load is discarded.
- A and B hold their value at all other times; partially loaded bytes stay visible during entry.
- byte_idx wraps 3 -> 0 only on phase change; no other wrap.
- Illegal phase 11 (unreachable) recovers to LOAD_A with A=B=0 on the next edge.

## Timing
- Reset (rst_n low, asynchronous): A=0, B=0, operands_valid=0, phase=00, byte_idx=0, synchronizers, stable levels, counters and edge registers all 0. Outputs reach reset values without a clock edge.
- Reset release mid-press: a button already held produces a pulse after full debounce latency; this counts as a fresh press.
- Press latency: the first edge sampling raw high is edge 1; the stable level flips on edge DB_CYCLES+2; the pulse is high after edge DB_CYCLES+3; A/B/phase/byte_idx update on edge DB_CYCLES+4.
- Maximum one commit per press regardless of hold time.
- All outputs are registered; no combinational path from sw or buttons to outputs.

## Configuration
- LOADER_DEBOUNCE_EN defined: debounce filter is present as above.
- Not defined: the filter is removed and the stable level equals the synchronizer output. Pulse is high after edge 3 and state updates on edge 4. DB_CYCLES and DB_W are ignored. Intended for fast simulation only.

## Test plan
- Reset, then with DB_CYCLES=4 press load 8 times with sw=0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> A=0x44332211, B=0x88776655, phase=10, operands_valid=1.
- Press btn_load once: assert it on edge 1 and hold it -> A byte0 updates exactly on edge 8; holding for 100 cycles commits only one byte.
- Bounce: btn_load high for 3 cycles, low for 2, repeated 5 times, then released -> no state change.
- READY then btn_load press -> phase=00, A=B=0, operands_valid=0, byte_idx=0; sw not stored. Then clr and load pressed on the same edge in LOAD_B byte 2 -> LOAD_A, A=B=0, load discarded.
- rst_n pulsed low mid-LOAD_B, between clock edges -> all outputs are 0 immediately; the next press writes A byte0.
- Compile without LOADER_DEBOUNCE_EN -> the A byte0 commit lands on edge 4 after the press.
